// File: rtl/mii_frame_sequencer.sv
// mii_frame_sequencer
//   Multi-frame Ethernet stimulus source on an XGMII-style bus (LANES = DATA_WIDTH/8).
//   Each frame: START, preamble x6, SFD, DA, SA, LEN, payload, then TERM, then an
//   inter-frame gap of IDLE words. Config is latched when a run starts.
//
//   Optional build macro MII_SEQ_ERR_INJECT_EN adds i_err_inject / i_err_frame_idx;
//   when armed, the first payload byte of the selected frame is inverted.
//
// Ports
//   clk, i_rst          clock, synchronous active-high reset
//   i_start / i_stop    run request (idle only) / abort request (busy only)
//   i_dest_address      DA, MSB byte first
//   i_src_address       SA, MSB byte first
//   i_payload_length    payload bytes per frame (clamped to PAYLOAD_MAX_SIZE)
//   i_mode              0 fixed pattern, 1 incrementing, 2 LFSR, 3 fixed pattern
//   i_frame_count       frames per run
//   i_ipg_words         IDLE words between TERM word and next START word (0 acts as 1)
//   o_mii_data/ctrl     bus data, per-lane control flag
//   o_tx_valid          high on START..TERM words
//   o_busy              run in progress
//   o_frame_done        pulse with each TERM word
//   o_done              pulse at end of run
module mii_frame_sequencer #(
    parameter int unsigned DATA_WIDTH           = 64,
    parameter int unsigned PAYLOAD_MAX_SIZE     = 1500,
    parameter logic [7:0]  PAYLOAD_CHAR_PATTERN = 8'h55,
    parameter int unsigned MAX_FRAMES           = 256,
    parameter logic [7:0]  IDLE_CODE            = 8'h07,
    parameter logic [7:0]  START_CODE           = 8'hFB,
    parameter logic [7:0]  TERM_CODE            = 8'hFD,
    localparam int unsigned LANES               = DATA_WIDTH / 8,
    localparam int unsigned CW                  = $clog2(MAX_FRAMES + 1)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [47:0]           i_dest_address,
    input  logic [47:0]           i_src_address,
    input  logic [15:0]           i_payload_length,
    input  logic [1:0]            i_mode,
    input  logic [CW-1:0]         i_frame_count,
    input  logic [7:0]            i_ipg_words,
`ifdef MII_SEQ_ERR_INJECT_EN
    input  logic                  i_err_inject,
    input  logic [CW-1:0]         i_err_frame_idx,
`endif
    output logic [DATA_WIDTH-1:0] o_mii_data,
    output logic [LANES-1:0]      o_mii_ctrl,
    output logic                  o_tx_valid,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_done
);

    localparam int unsigned HDR_BYTES = 22;
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {LANES{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] TERM_WORD = {{(LANES-1){IDLE_CODE}}, TERM_CODE};

    typedef enum logic [2:0] {StIdle, StFrame, StTerm, StGap, StDone} state_e;

    state_e                state_q, state_d;
    logic [47:0]           da_q, da_d, sa_q, sa_d;
    logic [15:0]           len_q, len_d;
    logic [16:0]           total_q, total_d;
    logic [1:0]            mode_q, mode_d;
    logic [CW-1:0]         count_q, count_d, frame_idx_q, frame_idx_d;
    logic [7:0]            ipg_q, ipg_d, gap_q, gap_d;
    logic [16:0]           pos_q, pos_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic                  abort_q, abort_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]      ctrl_q, ctrl_d;
    logic                  valid_q, valid_d, busy_q, busy_d;
    logic                  fdone_q, fdone_d, done_q, done_d;
`ifdef MII_SEQ_ERR_INJECT_EN
    logic                  err_q, err_d;
    logic [CW-1:0]         err_idx_q, err_idx_d;
`endif

    // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [7:0] hdr [32];

    always_comb begin
        for (int i = 0; i < 32; i++) hdr[i] = 8'h00;
        hdr[0] = START_CODE;
        for (int i = 1; i < 7; i++) hdr[i] = 8'h55;
        hdr[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            hdr[8 + i]  = da_q[47 - 8 * i -: 8];
            hdr[14 + i] = sa_q[47 - 8 * i -: 8];
        end
        hdr[20] = len_q[15:8];
        hdr[21] = len_q[7:0];
    end

    // Word at stream offset pos_q; lanes past the last byte carry TERM then IDLE.
    // The LFSR only advances on payload lanes so header lanes leave the seed intact.
    logic [DATA_WIDTH-1:0] frame_data;
    logic [LANES-1:0]      frame_ctrl;
    logic [7:0]            lfsr_next, lane_cur, lane_byte;
    logic [16:0]           lane_n, lane_k;

    always_comb begin
        frame_data = '0;
        frame_ctrl = '0;
        lane_cur   = lfsr_q;
        lane_byte  = '0;
        lane_n     = '0;
        lane_k     = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_n = pos_q + 17'(l);
            if (lane_n < total_q) begin
                if (lane_n < 17'(HDR_BYTES)) begin
                    frame_data[8*l +: 8] = hdr[lane_n[4:0]];
                    frame_ctrl[l]        = (lane_n == '0);
                end else begin
                    lane_k = lane_n - 17'(HDR_BYTES);
                    unique case (mode_q)
                        2'd1:    lane_byte = lane_k[7:0];
                        2'd2:    lane_byte = lane_cur;
                        default: lane_byte = PAYLOAD_CHAR_PATTERN;
                    endcase
`ifdef MII_SEQ_ERR_INJECT_EN
                    if (err_q && frame_idx_q == err_idx_q && lane_k == '0) begin
                        lane_byte = lane_byte ^ 8'hFF;
                    end
`endif
                    lane_cur             = lfsr_step(lane_cur);
                    frame_data[8*l +: 8] = lane_byte;
                end
            end else if (lane_n == total_q) begin
                frame_data[8*l +: 8] = TERM_CODE;
                frame_ctrl[l]        = 1'b1;
            end else begin
                frame_data[8*l +: 8] = IDLE_CODE;
                frame_ctrl[l]        = 1'b1;
            end
        end
        lfsr_next = lane_cur;
    end

    logic [31:0] pos_end;
    assign pos_end = 32'(pos_q) + LANES;

    always_comb begin
        state_d     = state_q;
        da_d        = da_q;
        sa_d        = sa_q;
        len_d       = len_q;
        total_d     = total_q;
        mode_d      = mode_q;
        count_d     = count_q;
        frame_idx_d = frame_idx_q;
        ipg_d       = ipg_q;
        gap_d       = gap_q;
        pos_d       = pos_q;
        lfsr_d      = lfsr_q;
        abort_d     = abort_q;
        data_d      = IDLE_WORD;
        ctrl_d      = '1;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        fdone_d     = 1'b0;
        done_d      = 1'b0;
`ifdef MII_SEQ_ERR_INJECT_EN
        err_d       = err_q;
        err_idx_d   = err_idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    da_d    = i_dest_address;
                    sa_d    = i_src_address;
                    len_d   = (32'(i_payload_length) > PAYLOAD_MAX_SIZE) ?
                              16'(PAYLOAD_MAX_SIZE) : i_payload_length;
                    total_d = 17'(len_d) + 17'(HDR_BYTES);
                    mode_d  = i_mode;
                    count_d = i_frame_count;
                    ipg_d   = (i_ipg_words == 8'd0) ? 8'd1 : i_ipg_words;
`ifdef MII_SEQ_ERR_INJECT_EN
                    err_d     = i_err_inject;
                    err_idx_d = i_err_frame_idx;
`endif
                    frame_idx_d = '0;
                    pos_d       = '0;
                    lfsr_d      = 8'hFF;
                    abort_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (i_frame_count == '0) ? StDone : StFrame;
                end
            end
            StFrame: begin
                valid_d = 1'b1;
                if (i_stop) begin
                    // Truncate: TERM in lane 0, skip the remaining frames
                    data_d  = TERM_WORD;
                    fdone_d = 1'b1;
                    state_d = StDone;
                end else begin
                    data_d = frame_data;
                    ctrl_d = frame_ctrl;
                    pos_d  = pos_q + 17'(LANES);
                    lfsr_d = lfsr_next;
                    if (pos_end > 32'(total_q)) begin
                        fdone_d     = 1'b1;
                        frame_idx_d = frame_idx_q + 1'b1;
                        gap_d       = ipg_q;
                        state_d     = StGap;
                    end else if (pos_end == 32'(total_q)) begin
                        // Last byte filled the top lane: TERM needs a word of its own
                        state_d = StTerm;
                    end
                end
            end
            StTerm: begin
                data_d      = TERM_WORD;
                valid_d     = 1'b1;
                fdone_d     = 1'b1;
                frame_idx_d = frame_idx_q + 1'b1;
                gap_d       = ipg_q;
                state_d     = i_stop ? StDone : StGap;
            end
            StGap: begin
                if (i_stop) abort_d = 1'b1;
                if (gap_q <= 8'd1) begin
                    if (!abort_q && !i_stop && frame_idx_q < count_q) begin
                        pos_d   = '0;
                        lfsr_d  = 8'hFF;
                        state_d = StFrame;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            da_q        <= '0;
            sa_q        <= '0;
            len_q       <= '0;
            total_q     <= '0;
            mode_q      <= '0;
            count_q     <= '0;
            frame_idx_q <= '0;
            ipg_q       <= 8'd1;
            gap_q       <= '0;
            pos_q       <= '0;
            lfsr_q      <= 8'hFF;
            abort_q     <= 1'b0;
            data_q      <= IDLE_WORD;
            ctrl_q      <= '1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fdone_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef MII_SEQ_ERR_INJECT_EN
            err_q       <= 1'b0;
            err_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            len_q       <= len_d;
            total_q     <= total_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            frame_idx_q <= frame_idx_d;
            ipg_q       <= ipg_d;
            gap_q       <= gap_d;
            pos_q       <= pos_d;
            lfsr_q      <= lfsr_d;
            abort_q     <= abort_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fdone_q     <= fdone_d;
            done_q      <= done_d;
`ifdef MII_SEQ_ERR_INJECT_EN
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
`endif
        end
    end

    assign o_mii_data   = data_q;
    assign o_mii_ctrl   = ctrl_q;
    assign o_tx_valid   = valid_q;
    assign o_busy       = busy_q;
    assign o_frame_done = fdone_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_mii_frame_sequencer.sv
// tb_mii_frame_sequencer
//   Directed bench: a 64-bit and a 32-bit instance share stimulus; words after each
//   start are captured into arrays and compared with hand-computed values.
module tb_mii_frame_sequencer;

    localparam int CW = 9;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] TERM0_W = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_start = 1'b0, i_stop = 1'b0;
    logic [47:0] i_dest_address = 48'h001122334455;
    logic [47:0] i_src_address  = 48'h66778899AABB;
    logic [15:0] i_payload_length = 16'd8;
    logic [1:0]  i_mode = 2'd0;
    logic [CW-1:0] i_frame_count = 9'd1;
    logic [7:0]  i_ipg_words = 8'd1;
`ifdef MII_SEQ_ERR_INJECT_EN
    logic        i_err_inject = 1'b0;
    logic [CW-1:0] i_err_frame_idx = '0;
`endif

    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        valid, busy, fdone, done;
    logic [31:0] data32;
    logic [3:0]  ctrl32;
    logic        valid32, busy32, fdone32, done32;

    int total = 0;
    int bad = 0;

    logic [63:0] cd [256];
    logic [7:0]  cc [256];
    logic        cv [256], cf [256], cn [256], cb [256];
    logic [31:0] cd32 [256];
    logic [3:0]  cc32 [256];
    logic        cf32 [256];

    always #5 clk = ~clk;

    mii_frame_sequencer #(.DATA_WIDTH(64)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_dest_address(i_dest_address), .i_src_address(i_src_address),
        .i_payload_length(i_payload_length), .i_mode(i_mode),
        .i_frame_count(i_frame_count), .i_ipg_words(i_ipg_words),
`ifdef MII_SEQ_ERR_INJECT_EN
        .i_err_inject(i_err_inject), .i_err_frame_idx(i_err_frame_idx),
`endif
        .o_mii_data(data), .o_mii_ctrl(ctrl), .o_tx_valid(valid), .o_busy(busy),
        .o_frame_done(fdone), .o_done(done)
    );

    mii_frame_sequencer #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_dest_address(i_dest_address), .i_src_address(i_src_address),
        .i_payload_length(i_payload_length), .i_mode(i_mode),
        .i_frame_count(i_frame_count), .i_ipg_words(i_ipg_words),
`ifdef MII_SEQ_ERR_INJECT_EN
        .i_err_inject(i_err_inject), .i_err_frame_idx(i_err_frame_idx),
`endif
        .o_mii_data(data32), .o_mii_ctrl(ctrl32), .o_tx_valid(valid32), .o_busy(busy32),
        .o_frame_done(fdone32), .o_done(done32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 frame_done, 1 done, 2 valid, 3 START word (64-bit)
    function automatic int count(input int sel, input int a, input int b);
        int c = 0;
        for (int i = a; i < b; i++) begin
            case (sel)
                0: c += int'(cf[i]);
                1: c += int'(cn[i]);
                2: c += int'(cv[i]);
                default: c += int'(cd[i] == START_W && cc[i] == 8'h01);
            endcase
        end
        return c;
    endfunction

    // Pulse start (edge E0), then record n words; cap[0] is the word after E0+1.
    task automatic run(input string tag, input int n, input int stop_at);
        int w;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            i_stop = (i == stop_at);
            step();
            cd[i] = data; cc[i] = ctrl; cv[i] = valid; cf[i] = fdone; cn[i] = done;
            cb[i] = busy;
            cd32[i] = data32; cc32[i] = ctrl32; cf32[i] = fdone32;
        end
        i_stop = 1'b0;
        w = 0;
        while ((busy || busy32) && w < 2000) begin
            step();
            w++;
        end
        chk({tag, "_run_ends"}, 64'(busy | busy32), 64'd0);
    endtask

    initial begin
        step();
        step();
        i_rst = 1'b0;
        chk("rst_data", data, IDLE_W);
        chk("rst_ctrl", 64'(ctrl), 64'hFF);
        chk("rst_flags", {60'd0, valid, busy, fdone, done}, 64'd0);

        // 1) one frame, len 8, fixed pattern
        i_frame_count = 9'd1; i_payload_length = 16'd8; i_mode = 2'd0; i_ipg_words = 8'd1;
        run("t1", 12, -1);
        chk("t1_w0", cd[0], START_W);
        chk("t1_w0_ctrl", 64'(cc[0]), 64'h01);
        chk("t1_w1", cd[1], 64'h7766554433221100);
        chk("t1_w2", cd[2], 64'h55550800BBAA9988);
        chk("t1_w3", cd[3], 64'h07FD555555555555);
        chk("t1_w3_ctrl", 64'(cc[3]), 64'hC0);
        chk("t1_w3_flags", {62'd0, cv[3], cf[3]}, 64'd3);
        chk("t1_gap", {cd[4][62:0], cv[4]}, {IDLE_W[62:0], 1'b0});
        chk("t1_done_at5", {62'd0, cn[5], cb[5]}, 64'd2);
        chk("t1_fd_count", 64'(count(0, 0, 12)), 64'd1);
        chk("t1_done_count", 64'(count(1, 0, 12)), 64'd1);

        // 2) three frames, len 64, ipg 2, incrementing
        i_frame_count = 9'd3; i_payload_length = 16'd64; i_mode = 2'd1; i_ipg_words = 8'd2;
        run("t2", 45, -1);
        chk("t2_f0_w2", cd[2], 64'h01004000BBAA9988);
        chk("t2_f0_w3", cd[3], 64'h0908070605040302);
        chk("t2_f0_last", cd[10], 64'h07FD3F3E3D3C3B3A);
        chk("t2_gap_valid", 64'(count(2, 11, 13)), 64'd0);
        chk("t2_gap_data", cd[12], IDLE_W);
        chk("t2_f1_start", cd[13], START_W);
        chk("t2_f1_w2", cd[15], 64'h01004000BBAA9988);
        chk("t2_f2_start", cd[26], START_W);
        chk("t2_f2_last", cd[36], 64'h07FD3F3E3D3C3B3A);
        chk("t2_starts", 64'(count(3, 0, 45)), 64'd3);
        chk("t2_fd_count", 64'(count(0, 0, 45)), 64'd3);
        chk("t2_done_at39", 64'(cn[39]), 64'd1);
        chk("t2_done_count", 64'(count(1, 0, 45)), 64'd1);

        // 3) exact fill: 64 bytes
        i_frame_count = 9'd1; i_payload_length = 16'd42; i_mode = 2'd1; i_ipg_words = 8'd1;
        run("t3", 20, -1);
        chk("t3_w7", cd[7], 64'h2928272625242322);
        chk("t3_w7_fd", 64'(cf[7]), 64'd0);
        chk("t3_term", cd[8], TERM0_W);
        chk("t3_term_ctrl", 64'(cc[8]), 64'hFF);
        chk("t3_term_flags", {62'd0, cv[8], cf[8]}, 64'd3);
        chk("t3_done_at10", 64'(cn[10]), 64'd1);
        chk("t3_32_w0", 64'(cd32[0]), 64'h555555FB);
        chk("t3_32_w0_ctrl", 64'(cc32[0]), 64'h1);
        chk("t3_32_w1", 64'(cd32[1]), 64'hD5555555);
        chk("t3_32_w15", 64'(cd32[15]), 64'h29282726);
        chk("t3_32_term", {28'd0, cc32[16], cd32[16]}, {28'd0, 4'hF, 32'h070707FD});
        chk("t3_32_fd", 64'(cf32[16]), 64'd1);

        // 4) LFSR payload, reseeded per frame
        i_frame_count = 9'd2; i_payload_length = 16'd4; i_mode = 2'd2; i_ipg_words = 8'd1;
        run("t4", 14, -1);
        chk("t4_w2", cd[2], 64'hFEFF0400BBAA9988);
        chk("t4_w3", cd[3], 64'h0707070707FDF8FC);
        chk("t4_w3_ctrl", 64'(cc[3]), 64'hFC);
        chk("t4_f1_w2", cd[7], 64'hFEFF0400BBAA9988);
        chk("t4_f1_w3", cd[8], 64'h0707070707FDF8FC);
        chk("t4_done_at10", 64'(cn[10]), 64'd1);

        // 5) abort in second frame of five
        i_frame_count = 9'd5; i_payload_length = 16'd8; i_mode = 2'd0; i_ipg_words = 8'd1;
        run("t5", 30, 6);
        chk("t5_f1_start", cd[5], START_W);
        chk("t5_trunc", cd[6], TERM0_W);
        chk("t5_trunc_ctrl", 64'(cc[6]), 64'hFF);
        chk("t5_trunc_flags", {62'd0, cv[6], cf[6]}, 64'd3);
        chk("t5_done_at7", {62'd0, cn[7], cb[7]}, 64'd2);
        chk("t5_no_valid_after", 64'(count(2, 7, 30)), 64'd0);
        chk("t5_fd_count", 64'(count(0, 0, 30)), 64'd2);
        chk("t5_starts", 64'(count(3, 0, 30)), 64'd2);

        // count = 0
        i_frame_count = 9'd0;
        run("t5z", 6, -1);
        chk("t5z_done_e1", {62'd0, cn[0], cb[0]}, 64'd2);
        chk("t5z_valid", 64'(count(2, 0, 6)), 64'd0);
        chk("t5z_done_count", 64'(count(1, 0, 6)), 64'd1);

        // 6) oversize length clamps to 1500
        i_frame_count = 9'd1; i_payload_length = 16'd2000; i_mode = 2'd0; i_ipg_words = 8'd1;
        run("t6", 200, -1);
        chk("t6_w2_len", cd[2], 64'h5555DC05BBAA9988);
        chk("t6_w189", cd[189], 64'h5555555555555555);
        chk("t6_last", cd[190], 64'h0707070707FD5555);
        chk("t6_last_ctrl", 64'(cc[190]), 64'hFC);
        chk("t6_fd_at190", 64'(cf[190]), 64'd1);
        chk("t6_done_at192", 64'(cn[192]), 64'd1);

`ifdef MII_SEQ_ERR_INJECT_EN
        i_frame_count = 9'd2; i_payload_length = 16'd8; i_mode = 2'd0;
        i_err_inject = 1'b1; i_err_frame_idx = 9'd1;
        run("t6e", 14, -1);
        i_err_inject = 1'b0;
        chk("t6e_f0_clean", cd[2], 64'h55550800BBAA9988);
        chk("t6e_f1_flip", cd[7], 64'h55AA0800BBAA9988);
`endif

        // start and stop together while idle: start wins
        i_frame_count = 9'd1; i_payload_length = 16'd8; i_stop = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0; i_stop = 1'b0;
        step();
        chk("ss_start_word", cd[0] ^ data ^ cd[0], START_W);
        step();
        chk("ss_w1_valid", {63'd0, valid}, 64'd1);

        // reset mid-frame
        i_rst = 1'b1;
        step();
        chk("midrst_data", data, IDLE_W);
        chk("midrst_flags", {56'd0, ctrl, 4'd0} | {60'd0, valid, busy, fdone, done},
            64'hFF0);
        i_rst = 1'b0;
        step();
        step();
        chk("midrst_no_term", {62'd0, valid, fdone}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
